risc_decode_stage: RTL and testbench
====================================

# risc_decode_stage

Registered instruction-decode stage for the RISC core, the parametrised successor to the fixed-width ISA definitions. It accepts a fetched instruction over a valid/ready handshake and produces a one-cycle-latency decoded control bundle for execute: register indices, sign-extended immediate, ALU op and datapath selects. It also detects and flags illegal encodings, inserts a one-cycle bubble on load-use hazards, and supports a synchronous flush from branch resolution.

## Interface
- XLEN, 32, data/address width; immediates sign-extended to XLEN (≥32)
- REG_ADDR_WIDTH, 5, register index width (instr fields truncated/zero-extended)
- EXT_ALU, 1, 1 = also decode AND/OR/SLT (R) and ANDI/ORI/SLTI (I); 0 = base set only
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of held and incoming instruction
- in_valid / in_ready  in / out  1  instruction handshake
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid / out_ready  out / in  1  decoded-bundle handshake
- out_pc  out  XLEN;  out_rs1, out_rs2, out_rd  out  REG_ADDR_WIDTH each
- out_imm  out  XLEN  sign-extended immediate (0 for R-type)
- out_alu_op  out  3  ADD 000, SUB 001, PASS_B 010, EQ_CHECK 011, AND 100, OR 101, SLT 110
- out_alu_src_b  out  1  0 = register, 1 = immediate
- out_reg_write, out_mem_read, out_mem_write, out_branch  out  1 each
- out_wb_src  out  2  00 ALU, 01 MEM
- out_illegal  out  1  encoding not recognised
- hazard_count  out  16  saturating count of inserted load-use bubbles

## Operation
- Decode by opcode [6:0]. OP_R 0110011: funct3 000 + funct7 0000000 ADD, 0100000 SUB; EXT_ALU: funct7 0 with funct3 111 AND, 110 OR, 010 SLT. reg_write=1, alu_src_b=0.
- OP_I 0010011: funct3 000 ADDI; EXT_ALU: 111 ANDI, 110 ORI, 010 SLTI. imm I-type, alu_src_b=1, reg_write=1.
- LOAD 0000011 funct3 010: ADD, imm I, mem_read=1, reg_write=1, wb_src=MEM.
- STORE 0100011 funct3 010: ADD, imm S = {instr[31:25],instr[11:7]}, mem_write=1.
- BRANCH 1100011 funct3 000 (BEQ): EQ_CHECK, alu_src_b=0, branch=1, imm B = {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
- Anything else: out_illegal=1; reg_write, mem_read, mem_write, branch all 0; alu_op ADD; bundle still delivered with out_valid.
- Source use: R/STORE/BRANCH use rs1+rs2; I/LOAD use rs1 only; illegal uses none.
- Output register loads when a transfer is accepted (in_valid && in_ready).
- Hazard H = in_valid && out_valid && out_mem_read && out_rd≠0 && incoming used rs matches out_rd.
- in_ready = (!out_valid || out_ready) && !H && !flush.
- On H with out_ready=1: load leaves, register goes empty (out_valid=0 next cycle) = one bubble; hazard_count += 1, saturating at 0xFFFF.
- flush=1: out_valid←0 next cycle regardless of out_ready; incoming instruction dropped; no hazard count. Flush has priority over every other event.

## Timing
- Reset: out_valid=0, all out_* fields 0, hazard_count=0; in_ready=1 in first cycle after reset release.
- Latency 1 cycle accept-to-out_valid; throughput 1 instruction/cycle without hazards.
- All out_* stable while out_valid && !out_ready.
- Simultaneous out_ready and new accept: bundle replaced in same edge, no gap.
- Reset asserted mid-transfer: bundle discarded immediately, outputs at reset values asynchronously.

## Test plan
- 0x002081B3 (ADD x3,x1,x2) → next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_op=000, reg_write=1, imm=0; 0x402081B3 → alu_op=001.
- 0x0080A283 (LW x5,8(x1)) then 0x00228333 (ADD x6,x5,x2), out_ready=1 → LW out, one out_valid=0 cycle, then ADD; hazard_count=1. Repeat with rd=x0 → no bubble.
- 0xFE20AE23 (SW x2,-4(x1)) → imm=0xFFFFFFFC, mem_write=1, alu_src_b=1; 0xFE208CE3 (BEQ x1,x2,-8) → imm=0xFFFFFFF8, branch=1, alu_op=011.
- EXT_ALU=0 with 0x0020F1B3 (AND) → out_illegal=1, reg_write=0; EXT_ALU=1 → alu_op=100, illegal=0.
- Hold out_ready=0 for 3 cycles → outputs stable, in_ready=0; then flush=1 → out_valid=0 next cycle, incoming word not delivered.
- Force 65 540 hazards → hazard_count stays 0xFFFF; rst_n low mid-stream → out_valid=0, count 0 immediately.

Source files
------------

// File: rtl/risc_decode_stage_if.sv
// Fetch-to-decode instruction handshake and the decoded control bundle handed to execute.
interface risc_decode_stage_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_instr;
    logic [XLEN-1:0]           in_pc;

    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_pc;
    logic [REG_ADDR_WIDTH-1:0] out_rs1;
    logic [REG_ADDR_WIDTH-1:0] out_rs2;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [XLEN-1:0]           out_imm;
    logic [2:0]                out_alu_op;
    logic                      out_alu_src_b;
    logic                      out_reg_write;
    logic                      out_mem_read;
    logic                      out_mem_write;
    logic                      out_branch;
    logic [1:0]                out_wb_src;
    logic                      out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_alu_src_b, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_wb_src, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_op, out_alu_src_b, out_reg_write, out_mem_read,
               out_mem_write, out_branch, out_wb_src, out_illegal
    );
endinterface

// File: rtl/risc_decode_stage.sv
// Registered decode stage: one-cycle decode into a control bundle, load-use bubble
// insertion with a saturating bubble counter, and synchronous flush.
module risc_decode_stage #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXT_ALU        = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    risc_decode_stage_if.slave  bus,
    output logic [15:0]         hazard_count_o
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] WB_MEM    = 2'b01;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_PASS_B = 3'b010,
        ALU_EQ     = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_SLT    = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           imm;
        logic [2:0]                alu_op;
        logic                      alu_src_b;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
        logic                      branch;
        logic [1:0]                wb_src;
        logic                      illegal;
    } bundle_t;

    // Instruction register fields are 5 bits; narrower/wider index widths truncate/zero-extend.
    function automatic logic [REG_ADDR_WIDTH-1:0] reg_idx(input logic [4:0] f);
        logic [REG_ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < REG_ADDR_WIDTH && i < 5; i++) r[i] = f[i];
        return r;
    endfunction

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];
    assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
    assign imm_b  = {{(XLEN-13){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                     bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};

    bundle_t bundle_q, bundle_d, dec;
    logic    valid_q, valid_d;
    logic [15:0] hazard_cnt_q, hazard_cnt_d;
    logic    legal, use_rs1, use_rs2, ext_hit, hazard, accept;
    alu_op_e ext_alu;

    always_comb begin
        ext_hit = 1'b0;
        ext_alu = ALU_ADD;
        if (EXT_ALU != 0) begin
            case (funct3)
                3'b111:  begin ext_hit = 1'b1; ext_alu = ALU_AND; end
                3'b110:  begin ext_hit = 1'b1; ext_alu = ALU_OR;  end
                3'b010:  begin ext_hit = 1'b1; ext_alu = ALU_SLT; end
                default: ;
            endcase
        end

        dec        = '0;
        dec.pc     = bus.in_pc;
        dec.rs1    = reg_idx(bus.in_instr[19:15]);
        dec.rs2    = reg_idx(bus.in_instr[24:20]);
        dec.rd     = reg_idx(bus.in_instr[11:7]);
        dec.alu_op = ALU_ADD;
        legal      = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;

        case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) legal = 1'b1;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    legal = 1'b1; dec.alu_op = ALU_SUB;
                end else if (ext_hit && funct7 == 7'b0000000) begin
                    legal = 1'b1; dec.alu_op = ext_alu;
                end
                dec.reg_write = legal;
                use_rs1       = legal;
                use_rs2       = legal;
            end
            OP_I: begin
                if (funct3 == 3'b000) legal = 1'b1;
                else if (ext_hit) begin
                    legal = 1'b1; dec.alu_op = ext_alu;
                end
                dec.imm       = legal ? imm_i : '0;
                dec.alu_src_b = legal;
                dec.reg_write = legal;
                use_rs1       = legal;
            end
            OP_LOAD: if (funct3 == 3'b010) begin
                legal = 1'b1; dec.imm = imm_i; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.mem_read = 1'b1; dec.wb_src = WB_MEM; use_rs1 = 1'b1;
            end
            OP_STORE: if (funct3 == 3'b010) begin
                legal = 1'b1; dec.imm = imm_s; dec.alu_src_b = 1'b1; dec.mem_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_BRANCH: if (funct3 == 3'b000) begin
                legal = 1'b1; dec.imm = imm_b; dec.alu_op = ALU_EQ; dec.branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: ;
        endcase
        dec.illegal = !legal;
    end

    // A held load whose destination feeds the incoming instruction forces one bubble.
    assign hazard = bus.in_valid && valid_q && bundle_q.mem_read && (bundle_q.rd != '0) &&
                    ((use_rs1 && dec.rs1 == bundle_q.rd) || (use_rs2 && dec.rs2 == bundle_q.rd));
    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !flush_i;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        valid_d      = valid_q;
        bundle_d     = bundle_q;
        hazard_cnt_d = hazard_cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
        if (!flush_i && hazard && bus.out_ready && hazard_cnt_q != 16'hFFFF)
            hazard_cnt_d = hazard_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            bundle_q     <= '0;
            hazard_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            bundle_q     <= bundle_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign bus.out_valid     = valid_q;
    assign bus.out_pc        = bundle_q.pc;
    assign bus.out_rs1       = bundle_q.rs1;
    assign bus.out_rs2       = bundle_q.rs2;
    assign bus.out_rd        = bundle_q.rd;
    assign bus.out_imm       = bundle_q.imm;
    assign bus.out_alu_op    = bundle_q.alu_op;
    assign bus.out_alu_src_b = bundle_q.alu_src_b;
    assign bus.out_reg_write = bundle_q.reg_write;
    assign bus.out_mem_read  = bundle_q.mem_read;
    assign bus.out_mem_write = bundle_q.mem_write;
    assign bus.out_branch    = bundle_q.branch;
    assign bus.out_wb_src    = bundle_q.wb_src;
    assign bus.out_illegal   = bundle_q.illegal;
    assign hazard_count_o    = hazard_cnt_q;
endmodule

// File: tb/tb_risc_decode_stage.sv
// Scoreboard bench for risc_decode_stage: reference decode per accepted word, compared on delivery.
module tb_risc_decode_stage;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [15:0] hc, hc0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    risc_decode_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) ifc ();
    risc_decode_stage_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) ifc0 ();

    assign ifc0.in_valid  = ifc.in_valid;
    assign ifc0.in_instr  = ifc.in_instr;
    assign ifc0.in_pc     = ifc.in_pc;
    assign ifc0.out_ready = ifc.out_ready;

    risc_decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .EXT_ALU(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(ifc), .hazard_count_o(hc));
    risc_decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .EXT_ALU(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(ifc0), .hazard_count_o(hc0));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [2:0]  op;
        logic        srcb, rw, mr, mw, br;
        logic [1:0]  wb;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc, input bit ext);
        exp_t e;
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        bit ext_f3 = ext && (f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2);
        logic [2:0] ext_op = (f3 == 3'd7) ? 3'd4 : (f3 == 3'd6) ? 3'd5 : 3'd6;
        e = '0; e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.ill = 1'b1;
        if (op == 7'b0110011) begin
            if (f3 == 3'd0 && f7 == 7'h00) e.ill = 1'b0;
            else if (f3 == 3'd0 && f7 == 7'h20) begin e.ill = 1'b0; e.op = 3'd1; end
            else if (ext_f3 && f7 == 7'h00) begin e.ill = 1'b0; e.op = ext_op; end
            e.rw = !e.ill;
        end else if (op == 7'b0010011) begin
            if (f3 == 3'd0) e.ill = 1'b0;
            else if (ext_f3) begin e.ill = 1'b0; e.op = ext_op; end
            if (!e.ill) begin e.rw = 1'b1; e.srcb = 1'b1; e.imm = {{20{w[31]}}, w[31:20]}; end
        end else if (op == 7'b0000011 && f3 == 3'd2) begin
            e.ill = 1'b0; e.imm = {{20{w[31]}}, w[31:20]}; e.srcb = 1'b1; e.rw = 1'b1;
            e.mr = 1'b1; e.wb = 2'b01;
        end else if (op == 7'b0100011 && f3 == 3'd2) begin
            e.ill = 1'b0; e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.srcb = 1'b1; e.mw = 1'b1;
        end else if (op == 7'b1100011 && f3 == 3'd0) begin
            e.ill = 1'b0; e.op = 3'd3; e.br = 1'b1;
            e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        end
        if (e.ill) e.op = 3'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a  = 5'($urandom_range(0, 7));
        logic [4:0]  b  = 5'($urandom_range(0, 7));
        logic [4:0]  d  = 5'($urandom_range(0, 7));
        logic [11:0] im = 12'($urandom);
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: return {7'h00, b, a, 3'd0, d, 7'b0110011};
            1: return {7'h20, b, a, 3'd0, d, 7'b0110011};
            2: return {7'h00, b, a, f3, d, 7'b0110011};
            3: return {im, a, f3, d, 7'b0010011};
            4: return {im, a, 3'd2, d, 7'b0000011};
            5: return {im[11:5], b, a, 3'd2, im[4:0], 7'b0100011};
            6: return {im[11:5], b, a, 3'd0, im[4:0], 7'b1100011};
            default: return $urandom;
        endcase
    endfunction

    // Delivery monitor: every out_valid && out_ready edge consumes one expected bundle.
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            exp_t act, e;
            act = {ifc.out_pc, ifc.out_rs1, ifc.out_rs2, ifc.out_rd, ifc.out_imm, ifc.out_alu_op,
                   ifc.out_alu_src_b, ifc.out_reg_write, ifc.out_mem_read, ifc.out_mem_write,
                   ifc.out_branch, ifc.out_wb_src, ifc.out_illegal};
            total++;
            if (sb.size() == 0) begin
                bad++; $display("FAIL sb_unexpected got=%h exp=none", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin bad++; $display("FAIL sb_bundle got=%h exp=%h", act, e); end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Entered and left at posedge+1; pushes the expectation once the word is accepted.
    task automatic send(input logic [31:0] w, input logic [31:0] pc, input bit rnd, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        ifc.in_valid = 1'b1; ifc.in_instr = w; ifc.in_pc = pc;
        while (!done) begin
            if (rnd) ifc.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ifc.in_ready) begin
                sb.push_back(ref_dec(w, pc, 1'b1)); done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    total++; bad++; done = 1'b1;
                    $display("FAIL send_timeout got=%0d exp<=50", stalls);
                end
            end
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ifc.out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL drain got=%0d exp=0", sb.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0; ifc.in_instr = '0; ifc.in_pc = '0; ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ifc.out_valid); end
        total++; if ({ifc.out_pc, ifc.out_imm, ifc.out_rd, ifc.out_alu_op, ifc.out_illegal} !== '0) begin
            bad++; $display("FAIL rst_fields got=%h exp=0", {ifc.out_pc, ifc.out_imm, ifc.out_rd}); end
        total++; if (hc !== 16'd0 || hc0 !== 16'd0) begin bad++; $display("FAIL rst_count got=%h/%h exp=0", hc, hc0); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", ifc.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_r();
        int st;
        ifc.out_ready = 1'b1;
        send(32'h002081B3, 32'h100, 1'b0, st);
        @(negedge clk);
        total++; if ({ifc.out_valid, ifc.out_rs1, ifc.out_rs2, ifc.out_rd} !== {1'b1, 5'd1, 5'd2, 5'd3}) begin
            bad++; $display("FAIL add_regs got=%b/%0d/%0d/%0d exp=1/1/2/3", ifc.out_valid, ifc.out_rs1, ifc.out_rs2, ifc.out_rd); end
        total++; if ({ifc.out_alu_op, ifc.out_reg_write, ifc.out_imm} !== {3'd0, 1'b1, 32'd0}) begin
            bad++; $display("FAIL add_ctrl got=%0d/%b/%h exp=0/1/0", ifc.out_alu_op, ifc.out_reg_write, ifc.out_imm); end
        @(posedge clk); #1;
        send(32'h402081B3, 32'h104, 1'b0, st);
        @(negedge clk);
        total++; if (ifc.out_alu_op !== 3'd1) begin bad++; $display("FAIL sub_op got=%0d exp=1", ifc.out_alu_op); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_load_use();
        int st;
        ifc.out_ready = 1'b1;
        send(32'h0080A283, 32'h200, 1'b0, st);
        ifc.in_valid = 1'b1; ifc.in_instr = 32'h00228333; ifc.in_pc = 32'h204;
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall got=%b exp=0", ifc.in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin
            bad++; $display("FAIL lu_bubble got=%b/%b exp=0/1", ifc.out_valid, ifc.in_ready); end
        sb.push_back(ref_dec(32'h00228333, 32'h204, 1'b1));
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        total++; if ({ifc.out_valid, ifc.out_rd} !== {1'b1, 5'd6}) begin
            bad++; $display("FAIL lu_add got=%b/%0d exp=1/6", ifc.out_valid, ifc.out_rd); end
        total++; if (hc !== 16'd1) begin bad++; $display("FAIL lu_count got=%0d exp=1", hc); end
        @(posedge clk); #1;
        send(32'h0080A003, 32'h208, 1'b0, st);
        send(32'h00200333, 32'h20C, 1'b0, st);
        total++; if (st != 0) begin bad++; $display("FAIL lu_x0 got=%0d exp=0", st); end
        send(32'h0080A283, 32'h210, 1'b0, st);
        send(32'h00128393, 32'h214, 1'b0, st);
        total++; if (st != 1) begin bad++; $display("FAIL lu_addi got=%0d exp=1", st); end
        send(32'h0080A283, 32'h218, 1'b0, st);
        send(32'h00510393, 32'h21C, 1'b0, st);
        total++; if (st != 0) begin bad++; $display("FAIL lu_rs2_unused got=%0d exp=0", st); end
        send(32'h0080A283, 32'h220, 1'b0, st);
        send(32'h0050A023, 32'h224, 1'b0, st);
        total++; if (st != 1) begin bad++; $display("FAIL lu_store got=%0d exp=1", st); end
        drain();
        total++; if (hc !== 16'd3) begin bad++; $display("FAIL lu_total got=%0d exp=3", hc); end
    endtask

    task automatic test_store_branch();
        int st;
        send(32'hFE20AE23, 32'h300, 1'b0, st);
        @(negedge clk);
        total++; if ({ifc.out_imm, ifc.out_mem_write, ifc.out_alu_src_b, ifc.out_reg_write} !== {32'hFFFFFFFC, 3'b110}) begin
            bad++; $display("FAIL sw got=%h/%b/%b exp=fffffffc/1/1", ifc.out_imm, ifc.out_mem_write, ifc.out_alu_src_b); end
        @(posedge clk); #1;
        send(32'hFE208CE3, 32'h304, 1'b0, st);
        @(negedge clk);
        total++; if ({ifc.out_imm, ifc.out_branch, ifc.out_alu_op, ifc.out_alu_src_b} !== {32'hFFFFFFF8, 1'b1, 3'd3, 1'b0}) begin
            bad++; $display("FAIL beq got=%h/%b/%0d exp=fffffff8/1/3", ifc.out_imm, ifc.out_branch, ifc.out_alu_op); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_ext_alu();
        int st;
        send(32'h0020F1B3, 32'h400, 1'b0, st);
        @(negedge clk);
        total++; if ({ifc0.out_valid, ifc0.out_illegal, ifc0.out_reg_write} !== 3'b110) begin
            bad++; $display("FAIL base_and got=%b%b%b exp=110", ifc0.out_valid, ifc0.out_illegal, ifc0.out_reg_write); end
        total++; if ({ifc.out_alu_op, ifc.out_illegal} !== {3'd4, 1'b0}) begin
            bad++; $display("FAIL ext_and got=%0d/%b exp=4/0", ifc.out_alu_op, ifc.out_illegal); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_stall_flush();
        int st;
        ifc.out_ready = 1'b0;
        send(32'h00510393, 32'h500, 1'b0, st);
        ifc.in_valid = 1'b1; ifc.in_instr = 32'h002081B3; ifc.in_pc = 32'h504;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if ({ifc.out_valid, ifc.out_pc, ifc.out_imm, ifc.in_ready} !== {1'b1, 32'h500, 32'd5, 1'b0}) begin
                bad++; $display("FAIL hold%0d got=%b/%h/%h/%b exp=1/500/5/0", i, ifc.out_valid, ifc.out_pc, ifc.out_imm, ifc.in_ready); end
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", ifc.in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL flush_gone%0d got=%b exp=0", i, ifc.out_valid); end
        end
        @(posedge clk); #1;
        send(32'h0080A283, 32'h508, 1'b0, st);
        ifc.in_valid = 1'b1; ifc.in_instr = 32'h00228333; ifc.in_pc = 32'h50C; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ifc.in_valid = 1'b0;
        @(negedge clk);
        total++; if ({ifc.out_valid, hc} !== {1'b0, 16'd3}) begin
            bad++; $display("FAIL flush_hazard got=%b/%0d exp=0/3", ifc.out_valid, hc); end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_saturate();
        int st;
        logic [16:0] exp_c;
        force dut.hazard_cnt_q = 16'hFFFC;
        @(posedge clk); #1;
        release dut.hazard_cnt_q;
        @(negedge clk);
        total++; if (hc !== 16'hFFFC) begin bad++; $display("FAIL sat_preload got=%h exp=fffc", hc); end
        @(posedge clk); #1;
        send(32'h0002A283, 32'h600, 1'b0, st);
        for (int i = 1; i <= 6; i++) begin
            send(32'h0002A283, 32'h600 + 32'(4 * i), 1'b0, st);
            exp_c = 17'h0FFFC + 17'(i);
            if (exp_c > 17'h0FFFF) exp_c = 17'h0FFFF;
            total++; if ({st[0], hc} !== {1'b1, exp_c[15:0]}) begin
                bad++; $display("FAIL sat%0d got=%0d/%h exp=1/%h", i, st, hc, exp_c[15:0]); end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int st;
        for (int i = 0; i < 80; i++) send(rand_instr(), 32'h1000 + 32'(4 * i), 1'b1, st);
        drain();
        total++; if (hc !== 16'hFFFF) begin bad++; $display("FAIL b2b_count got=%h exp=ffff", hc); end
    endtask

    task automatic test_reset_mid();
        int st;
        ifc.out_ready = 1'b1;
        send(32'h002081B3, 32'h700, 1'b0, st);
        send(32'h00128393, 32'h704, 1'b0, st);
        #1 rst_n = 1'b0;
        #1;
        total++; if ({ifc.out_valid, hc, ifc.out_pc, ifc.out_rd} !== '0) begin
            bad++; $display("FAIL rst_mid got=%b/%h/%h/%0d exp=0", ifc.out_valid, hc, ifc.out_pc, ifc.out_rd); end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if ({ifc.out_valid, ifc.in_ready} !== 2'b01) begin
            bad++; $display("FAIL rst_mid_after got=%b/%b exp=0/1", ifc.out_valid, ifc.in_ready); end
        @(posedge clk); #1;
        send(32'h402081B3, 32'h708, 1'b0, st);
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_load_use();
        test_store_branch();
        test_ext_alu();
        test_stall_flush();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
